// File: rtl/id_exe_stage_reg_pkg.sv
// Shared constants and types for the ID/EXE pipeline register: field widths,
// enable levels and execute-command encodings (NOP/reset value is all zeros).
package id_exe_stage_reg_pkg;

    localparam int unsigned EXECUTE_COMMAND_LEN = 4;
    localparam int unsigned REG_ADDR_LEN        = 4;
    localparam int unsigned SHIFT_OPERAND_LEN   = 12;
    localparam int unsigned SIGNED_IMM_LEN      = 24;
    localparam int unsigned PERF_CNT_LEN        = 16;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Several ARM opcodes share an ALU command, so these stay plain constants.
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_NOP = 4'b0000;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_MVN = 4'b1001;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_AND = 4'b0110;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_EOR = 4'b1000;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
        logic imm;
    } ctrl_bits_t;

    localparam ctrl_bits_t CTRL_NOP = '{
        wb_en: DISABLE, mem_r_en: DISABLE, mem_w_en: DISABLE,
        b: DISABLE, s: DISABLE, imm: DISABLE
    };

    // A bubble from ID must not write back, touch memory, branch or set flags.
    function automatic ctrl_bits_t gate_ctrl(input ctrl_bits_t c, input logic valid);
        return valid ? c : CTRL_NOP;
    endfunction

    function automatic logic [PERF_CNT_LEN-1:0] sat_inc(input logic [PERF_CNT_LEN-1:0] v);
        return (v == {PERF_CNT_LEN{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/id_exe_stage_reg_pipe_field_reg.sv
// One group of pipeline-register bits: clear on rst or flush, hold on freeze,
// otherwise load d. rst and flush are synchronous.
module id_exe_stage_reg_pipe_field_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q_q <= '0;
        end else if (!freeze) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze (stall), flush (bubble) and valid gating.
// Define ID_EXE_PERF_CNT_EN to add saturating stall_cnt/flush_cnt outputs.
module id_exe_stage_reg
    import id_exe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned EXE_CMD_LEN  = EXECUTE_COMMAND_LEN,
    parameter int unsigned REG_ADDR_LEN = id_exe_stage_reg_pkg::REG_ADDR_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic [DATA_WIDTH-1:0]     pc_in,
    input  logic                      wb_en_in,
    input  logic                      mem_r_en_in,
    input  logic                      mem_w_en_in,
    input  logic                      b_in,
    input  logic                      s_in,
    input  logic                      imm_in,
    input  logic [EXE_CMD_LEN-1:0]    exe_cmd_in,
    input  logic [DATA_WIDTH-1:0]     val_rn_in,
    input  logic [DATA_WIDTH-1:0]     val_rm_in,
    input  logic [11:0]               shift_operand_in,
    input  logic [23:0]               signed_imm_24_in,
    input  logic [REG_ADDR_LEN-1:0]   dest_in,
    input  logic [REG_ADDR_LEN-1:0]   src1_in,
    input  logic [REG_ADDR_LEN-1:0]   src2_in,
    input  logic                      carry_in,
    output logic [DATA_WIDTH-1:0]     pc_out,
    output logic                      wb_en_out,
    output logic                      mem_r_en_out,
    output logic                      mem_w_en_out,
    output logic                      b_out,
    output logic                      s_out,
    output logic                      imm_out,
    output logic [EXE_CMD_LEN-1:0]    exe_cmd_out,
    output logic [DATA_WIDTH-1:0]     val_rn_out,
    output logic [DATA_WIDTH-1:0]     val_rm_out,
    output logic [11:0]               shift_operand_out,
    output logic [23:0]               signed_imm_24_out,
    output logic [REG_ADDR_LEN-1:0]   dest_out,
    output logic [REG_ADDR_LEN-1:0]   src1_out,
    output logic [REG_ADDR_LEN-1:0]   src2_out,
    output logic                      carry_out,
`ifdef ID_EXE_PERF_CNT_EN
    output logic [PERF_CNT_LEN-1:0]   stall_cnt,
    output logic [PERF_CNT_LEN-1:0]   flush_cnt,
`endif
    output logic                      valid_out
);

    localparam int unsigned CTRL_W = 1 + $bits(ctrl_bits_t) + EXE_CMD_LEN;
    localparam int unsigned DATA_W = 3 * DATA_WIDTH + SHIFT_OPERAND_LEN + SIGNED_IMM_LEN + 1;
    localparam int unsigned ADDR_W = 3 * REG_ADDR_LEN;

    ctrl_bits_t ctrl_raw, ctrl_gated, ctrl_q;

    logic [CTRL_W-1:0] ctrl_grp_d, ctrl_grp_q;
    logic [DATA_W-1:0] data_grp_d, data_grp_q;
    logic [ADDR_W-1:0] addr_grp_d, addr_grp_q;

    always_comb begin
        ctrl_raw          = CTRL_NOP;
        ctrl_raw.wb_en    = wb_en_in;
        ctrl_raw.mem_r_en = mem_r_en_in;
        ctrl_raw.mem_w_en = mem_w_en_in;
        ctrl_raw.b        = b_in;
        ctrl_raw.s        = s_in;
        ctrl_raw.imm      = imm_in;
        ctrl_gated        = gate_ctrl(ctrl_raw, valid_in);
    end

    assign ctrl_grp_d = {valid_in, ctrl_gated, exe_cmd_in};
    assign data_grp_d = {pc_in, val_rn_in, val_rm_in, shift_operand_in,
                         signed_imm_24_in, carry_in};
    assign addr_grp_d = {dest_in, src1_in, src2_in};

    id_exe_stage_reg_pipe_field_reg #(
        .WIDTH (CTRL_W)
    ) u_ctrl_reg (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .freeze (freeze),
        .d      (ctrl_grp_d),
        .q      (ctrl_grp_q)
    );

    id_exe_stage_reg_pipe_field_reg #(
        .WIDTH (DATA_W)
    ) u_data_reg (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .freeze (freeze),
        .d      (data_grp_d),
        .q      (data_grp_q)
    );

    id_exe_stage_reg_pipe_field_reg #(
        .WIDTH (ADDR_W)
    ) u_addr_reg (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .freeze (freeze),
        .d      (addr_grp_d),
        .q      (addr_grp_q)
    );

    assign {valid_out, ctrl_q, exe_cmd_out} = ctrl_grp_q;
    assign {pc_out, val_rn_out, val_rm_out, shift_operand_out,
            signed_imm_24_out, carry_out} = data_grp_q;
    assign {dest_out, src1_out, src2_out} = addr_grp_q;

    assign wb_en_out    = ctrl_q.wb_en;
    assign mem_r_en_out = ctrl_q.mem_r_en;
    assign mem_w_en_out = ctrl_q.mem_w_en;
    assign b_out        = ctrl_q.b;
    assign s_out        = ctrl_q.s;
    assign imm_out      = ctrl_q.imm;

`ifdef ID_EXE_PERF_CNT_EN
    logic [PERF_CNT_LEN-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_LEN-1:0] flush_cnt_q, flush_cnt_d;

    // A flush that coincides with freeze is counted as a flush only.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (freeze) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed self-checking bench for id_exe_stage_reg; perf counter checks are
// built only when ID_EXE_PERF_CNT_EN is defined.
module tb_id_exe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, valid_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, carry_in;
    logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;

    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, carry_out;
    logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic        valid_out;
`ifdef ID_EXE_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .valid_in          (valid_in),
        .pc_in             (pc_in),
        .wb_en_in          (wb_en_in),
        .mem_r_en_in       (mem_r_en_in),
        .mem_w_en_in       (mem_w_en_in),
        .b_in              (b_in),
        .s_in              (s_in),
        .imm_in            (imm_in),
        .exe_cmd_in        (exe_cmd_in),
        .val_rn_in         (val_rn_in),
        .val_rm_in         (val_rm_in),
        .shift_operand_in  (shift_operand_in),
        .signed_imm_24_in  (signed_imm_24_in),
        .dest_in           (dest_in),
        .src1_in           (src1_in),
        .src2_in           (src2_in),
        .carry_in          (carry_in),
        .pc_out            (pc_out),
        .wb_en_out         (wb_en_out),
        .mem_r_en_out      (mem_r_en_out),
        .mem_w_en_out      (mem_w_en_out),
        .b_out             (b_out),
        .s_out             (s_out),
        .imm_out           (imm_out),
        .exe_cmd_out       (exe_cmd_out),
        .val_rn_out        (val_rn_out),
        .val_rm_out        (val_rm_out),
        .shift_operand_out (shift_operand_out),
        .signed_imm_24_out (signed_imm_24_out),
        .dest_out          (dest_out),
        .src1_out          (src1_out),
        .src2_out          (src2_out),
        .carry_out         (carry_out),
`ifdef ID_EXE_PERF_CNT_EN
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt),
`endif
        .valid_out         (valid_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs set after this apply to the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic v);
        valid_in = v; wb_en_in = v; mem_r_en_in = v; mem_w_en_in = v;
        b_in = v; s_in = v; imm_in = v; carry_in = v;
        pc_in = {32{v}}; val_rn_in = {32{v}}; val_rm_in = {32{v}};
        exe_cmd_in = {4{v}}; dest_in = {4{v}}; src1_in = {4{v}}; src2_in = {4{v}};
        shift_operand_in = {12{v}}; signed_imm_24_in = {24{v}};
    endtask

    initial begin
        // Reset dominates even with freeze/flush and all inputs high.
        drive_all(1'b1);
        rst = 1'b1; freeze = 1'b1; flush = 1'b1;
        step();
        step();
        chk("rst_valid",   valid_out,   0);
        chk("rst_pc",      pc_out,      0);
        chk("rst_exe_cmd", exe_cmd_out, 0);
        chk("rst_wb",      wb_en_out,   0);
        chk("rst_rn",      val_rn_out,  0);
        chk("rst_dest",    dest_out,    0);
        chk("rst_imm24",   signed_imm_24_out, 0);

        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        pc_in = 32'h0000_0004; exe_cmd_in = 4'b0010;
        step();
        chk("rel_pc",      pc_out,      32'h4);
        chk("rel_exe_cmd", exe_cmd_out, 4'b0010);
        chk("rel_valid",   valid_out,   1);
        chk("rel_shift",   shift_operand_out, 12'hFFF);
        chk("rel_carry",   carry_out,   1);

        // ADD r3, 5, 7
        drive_all(1'b0);
        valid_in = 1'b1; wb_en_in = 1'b1; exe_cmd_in = 4'b0010;
        pc_in = 32'h8; val_rn_in = 32'd5; val_rm_in = 32'd7; dest_in = 4'd3;
        src1_in = 4'd1; src2_in = 4'd2;
        step();
        chk("add_wb",    wb_en_out,  1);
        chk("add_rn",    val_rn_out, 5);
        chk("add_rm",    val_rm_out, 7);
        chk("add_dest",  dest_out,   3);
        chk("add_src2",  src2_out,   2);
        chk("add_valid", valid_out,  1);
        chk("add_memw",  mem_w_en_out, 0);

        // Freeze: A held for three edges while inputs present B.
        pc_in = 32'h10; val_rn_in = 32'h11; dest_in = 4'd5; mem_w_en_in = 1'b1;
        step();
        chk("a_pc", pc_out, 32'h10);
        pc_in = 32'h20; val_rn_in = 32'h22; dest_in = 4'd6; mem_w_en_in = 1'b0;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_pc",   pc_out,       32'h10);
            chk("frz_rn",   val_rn_out,   32'h11);
            chk("frz_memw", mem_w_en_out, 1);
        end
        freeze = 1'b0;
        step();
        chk("unfrz_pc",   pc_out,   32'h20);
        chk("unfrz_dest", dest_out, 6);

        // Flush overrides freeze; back-to-back flushes give back-to-back bubbles.
        pc_in = 32'h30; mem_w_en_in = 1'b1; b_in = 1'b1; s_in = 1'b1;
        step();
        chk("pre_flush_memw", mem_w_en_out, 1);
        freeze = 1'b1; flush = 1'b1;
        step();
        chk("fl_memw",  mem_w_en_out, 0);
        chk("fl_valid", valid_out,    0);
        chk("fl_b",     b_out,        0);
        chk("fl_s",     s_out,        0);
        chk("fl_pc",    pc_out,       0);
        freeze = 1'b0;
        step();
        chk("fl2_valid", valid_out, 0);
        chk("fl2_wb",    wb_en_out, 0);
        flush = 1'b0;
        step();
        chk("post_fl_pc",    pc_out,    32'h30);
        chk("post_fl_valid", valid_out, 1);

        // Invalid slot: controls gated, data still flows.
        drive_all(1'b0);
        valid_in = 1'b0; wb_en_in = 1'b1; b_in = 1'b1; mem_r_en_in = 1'b1;
        val_rn_in = 32'h99; pc_in = 32'h40;
        step();
        chk("inv_wb",    wb_en_out,    0);
        chk("inv_b",     b_out,        0);
        chk("inv_memr",  mem_r_en_out, 0);
        chk("inv_valid", valid_out,    0);
        chk("inv_rn",    val_rn_out,   32'h99);

        // Reset during a stall wins; loading resumes right after.
        valid_in = 1'b1; pc_in = 32'h50;
        freeze = 1'b1; rst = 1'b1;
        step();
        chk("rst_frz_pc", pc_out, 0);
        rst = 1'b0; freeze = 1'b0;
        step();
        chk("rst_rel_pc",    pc_out,    32'h50);
        chk("rst_rel_valid", valid_out, 1);

`ifdef ID_EXE_PERF_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("pc_rst_stall", stall_cnt, 0);
        chk("pc_rst_flush", flush_cnt, 0);
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) step();
        freeze = 1'b0; flush = 1'b1;
        for (int i = 0; i < 2; i++) step();
        freeze = 1'b1;
        step();
        freeze = 1'b0; flush = 1'b0;
        chk("pc_stall", stall_cnt, 4);
        chk("pc_flush", flush_cnt, 3);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) step();
        freeze = 1'b0;
        chk("pc_stall_sat", stall_cnt, 16'hFFFF);
        chk("pc_flush_hold", flush_cnt, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register between the decode (ID) stage and the execute (EXE) stage of the 5-stage ARM core.
- Captures the decode control word (wb/mem/branch/status enables, execute command) together with the operand values, immediates, PC and register addresses.
- Supports freeze for hazard stalls, flush for taken branches, and a valid bit marking bubbles.

Parameters:
- DATA_WIDTH, 32, width of PC, val_rn, val_rm.
- EXE_CMD_LEN, 4, width of execute command.
- REG_ADDR_LEN, 4, register-file address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hold all contents (hazard unit stall).
- flush  in  1  insert bubble (branch taken in EXE).
- valid_in  in  1  ID holds a real instruction.
- pc_in  in  DATA_WIDTH  PC+4 of the instruction.
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in  in  1 each  decode control bits.
- exe_cmd_in  in  EXE_CMD_LEN  ALU command.
- val_rn_in, val_rm_in  in  DATA_WIDTH  register-file read data.
- shift_operand_in  in  12  shifter operand field.
- signed_imm_24_in  in  24  branch offset.
- dest_in, src1_in, src2_in  in  REG_ADDR_LEN  destination and source register numbers, used for forwarding.
- carry_in  in  1  C flag from the status register.
- Outputs: all `_in` fields repeated with an `_out` suffix, same widths, registered.
- valid_out  out  1  registered valid.

Behaviour:
- Latency: one cycle. Fields sampled at edge N appear on the outputs after edge N.
- Priority per edge: rst > flush > freeze > load.
- rst: every output goes to 0, including valid_out, exe_cmd_out, pc_out and data fields.
- flush=1 (regardless of freeze): valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out and s_out go to 0; all other fields also clear to 0.
  - The result is a clean NOP bubble: no write-back, no memory access, no branch, no flag update.
- freeze=1 with flush=0: all outputs hold their previous values; inputs are ignored.
- Otherwise: all outputs load the corresponding inputs.
- valid_in=0 during a load: control bits are loaded as 0 (gated by valid_in); data fields load normally.
- No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush: reset wins in that cycle. Normal loading resumes on the first edge after rst deasserts.
- Back-to-back flushes produce consecutive bubbles.
- freeze held for N cycles keeps the contents stable for N edges. The instruction advances on the first edge with freeze=0.

Optional Feature:
- Macro: ID_EXE_PERF_CNT_EN.
- Defined: adds outputs stall_cnt (16 bits) and flush_cnt (16 bits).
  - stall_cnt increments on each edge where freeze=1 and flush=0.
  - flush_cnt increments on each edge where flush=1.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Not defined: the counters and ports are absent. Behaviour is otherwise identical.

Decomposition:
- Defines.v (shared include) holds EXECUTE_COMMAND_LEN, REG_ADDR_LEN, the ENABLE/DISABLE constants and the EXE command encodings, used for the NOP/reset value 0.
- One natural sub-module, pipe_field_reg:
  - Parameterised WIDTH, with clk, rst, flush, freeze, d, q.
  - Synchronous clear on rst or flush; hold on freeze.
  - Instantiated once per field group: control, data, addresses.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs driven to 1s, then release with freeze=0, flush=0 → all outputs 0 during reset. On the first edge after release, outputs equal the inputs (pc_out=32'h00000004, exe_cmd_out=4'b0010).
- Load: ADD with wb_en_in=1, val_rn_in=32'd5, val_rm_in=32'd7, dest_in=4'd3 → next cycle wb_en_out=1, val_rn_out=5, val_rm_out=7, dest_out=3, valid_out=1.
- Freeze: load instruction A, then freeze=1 for 3 cycles while the inputs change to B → outputs remain A for 3 edges. B appears on the edge after freeze drops.
- Flush over freeze: freeze=1 and flush=1 together with mem_w_en previously 1 → next edge mem_w_en_out=0, valid_out=0, b_out=0, s_out=0.
- Invalid input: valid_in=0 with wb_en_in=1 and b_in=1 → wb_en_out=0, b_out=0, valid_out=0.
- Perf counters, with ID_EXE_PERF_CNT_EN defined: 4 freeze cycles, 2 flush cycles and 1 cycle with both → stall_cnt=4, flush_cnt=3. A forced count preload of 16'hFFFE followed by 3 freezes gives stall_cnt=16'hFFFF.
